// File: rtl/dmac_xfer_counter_if.sv
// Strobe/flag bundle between channel_ctrl (master) and the transfer counter (slave).
interface dmac_xfer_counter_if #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 5
);
  logic [CNT_W-1:0]   cfg_tsize;
  logic [BURST_W-1:0] cfg_bsize;
  logic               t_sel;
  logic               ts_en;
  logic               b_sel;
  logic               burst_en;
  logic               count_en;
  logic               phase_start;
  logic               bsz;
  logic               tsz;
  logic               tslb;
  logic [CNT_W-1:0]   rem_beats;
  logic [BURST_W-1:0] burst_len;
  logic [BURST_W-1:0] beat_cnt;

  modport master (
    output cfg_tsize, cfg_bsize, t_sel, ts_en, b_sel, burst_en, count_en, phase_start,
    input  bsz, tsz, tslb, rem_beats, burst_len, beat_cnt
  );

  modport slave (
    input  cfg_tsize, cfg_bsize, t_sel, ts_en, b_sel, burst_en, count_en, phase_start,
    output bsz, tsz, tslb, rem_beats, burst_len, beat_cnt
  );
endinterface

// File: rtl/dmac_xfer_counter.sv
// Remaining-beat / burst-length / phase-beat bookkeeping for one DMA channel.
// Flags are decoded from registers only, so they trail the causing strobe by one cycle.
module dmac_xfer_counter #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  dmac_xfer_counter_if.slave  bus
);
  localparam int PAD_W = CNT_W - BURST_W;

  logic [CNT_W-1:0]   rem_q,   rem_d;
  logic [BURST_W-1:0] blen_q,  blen_d;
  logic [BURST_W-1:0] beat_q,  beat_d;

  logic [BURST_W-1:0] eff_b;
  logic [CNT_W-1:0]   eff_b_ext;
  logic [CNT_W-1:0]   blen_ext;
  logic [CNT_W-1:0]   bsrc;
  logic               ts_load;
  logic               ts_dec;

  assign eff_b     = (bus.cfg_bsize == '0) ? BURST_W'(1) : bus.cfg_bsize;
  assign eff_b_ext = {{PAD_W{1'b0}}, eff_b};
  assign blen_ext  = {{PAD_W{1'b0}}, blen_q};
  assign ts_load   = bus.ts_en &  bus.t_sel;
  assign ts_dec    = bus.ts_en & ~bus.t_sel;
  // An initial load in the same cycle sizes the first burst from the new total.
  assign bsrc      = ts_load ? bus.cfg_tsize : rem_q;

  always_comb begin
    rem_d = rem_q;
    if (ts_load)
      rem_d = bus.cfg_tsize;
    else if (ts_dec)
      rem_d = (rem_q > blen_ext) ? (rem_q - blen_ext) : '0;
  end

  always_comb begin
    blen_d = blen_q;
    if (bus.burst_en) begin
      if (bus.b_sel)
        blen_d = rem_q[BURST_W-1:0];
      else if (bsrc < eff_b_ext)
        blen_d = bsrc[BURST_W-1:0];
      else
        blen_d = eff_b;
    end
  end

  always_comb begin
    beat_d = beat_q;
    if (bus.count_en && bus.phase_start)
      beat_d = BURST_W'(1);
    else if (bus.burst_en)
      beat_d = '0;
    else if (bus.count_en && (beat_q < blen_q))
      beat_d = beat_q + BURST_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      blen_q <= '0;
      beat_q <= '0;
    end else begin
      rem_q  <= rem_d;
      blen_q <= blen_d;
      beat_q <= beat_d;
    end
  end

  assign bus.rem_beats = rem_q;
  assign bus.burst_len = blen_q;
  assign bus.beat_cnt  = beat_q;
  assign bus.tsz       = (rem_q == '0);
  assign bus.bsz       = (blen_q != '0) && (beat_q == blen_q);
  assign bus.tslb      = (rem_q != '0) && (rem_q < eff_b_ext);
endmodule

// File: tb/tb_dmac_xfer_counter.sv
// Directed bench for dmac_xfer_counter: integer reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_dmac_xfer_counter;
  localparam int CNT_W   = 16;
  localparam int BURST_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   npass = 0;
  int   ntot  = 0;

  dmac_xfer_counter_if #(.CNT_W(CNT_W), .BURST_W(BURST_W)) bus ();

  dmac_xfer_counter #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model in plain integers.
  int m_rem, m_blen, m_beat;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rem = 0; m_blen = 0; m_beat = 0;
    end else begin
      int eb, nr, nb, nc, src;
      eb  = (bus.cfg_bsize == 0) ? 1 : int'(bus.cfg_bsize);
      nr  = m_rem; nb = m_blen; nc = m_beat;
      if (bus.ts_en) nr = bus.t_sel ? int'(bus.cfg_tsize) : ((m_rem - m_blen < 0) ? 0 : m_rem - m_blen);
      if (bus.burst_en) begin
        if (bus.b_sel) nb = m_rem % 32;
        else begin
          src = (bus.ts_en && bus.t_sel) ? int'(bus.cfg_tsize) : m_rem;
          nb  = (src < eb) ? src : eb;
        end
        nc = 0;
      end
      if (bus.count_en) begin
        if (bus.phase_start) nc = 1;
        else if (!bus.burst_en) nc = (m_beat + 1 > m_blen) ? m_blen : m_beat + 1;
      end
      m_rem = nr; m_blen = nb; m_beat = nc;
    end
  end

  function automatic int exp_tslb();
    int eb;
    eb = (bus.cfg_bsize == 0) ? 1 : int'(bus.cfg_bsize);
    return (m_rem > 0 && m_rem < eb) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    ntot++;
    if (int'(bus.rem_beats) == m_rem && int'(bus.burst_len) == m_blen && int'(bus.beat_cnt) == m_beat &&
        bus.tsz === (m_rem == 0) && bus.bsz === (m_blen != 0 && m_beat == m_blen) &&
        int'(bus.tslb) == exp_tslb())
      npass++;
    else
      $display("FAIL model t=%0t: dut rem=%0d blen=%0d beat=%0d tsz=%b bsz=%b tslb=%b, want rem=%0d blen=%0d beat=%0d tslb=%0d",
               $time, bus.rem_beats, bus.burst_len, bus.beat_cnt, bus.tsz, bus.bsz, bus.tslb,
               m_rem, m_blen, m_beat, exp_tslb());
  end

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic step(input logic tse, input logic ts, input logic be, input logic bs,
                      input logic ce, input logic ps);
    bus.ts_en = tse; bus.t_sel = ts; bus.burst_en = be; bus.b_sel = bs;
    bus.count_en = ce; bus.phase_start = ps;
    @(posedge clk); #1;
    bus.ts_en = 0; bus.t_sel = 0; bus.burst_en = 0; bus.b_sel = 0;
    bus.count_en = 0; bus.phase_start = 0;
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, (i == 0));
  endtask

  task automatic load(input int ts, input int bs);
    bus.cfg_tsize = CNT_W'(ts); bus.cfg_bsize = BURST_W'(bs);
    step(1, 1, 1, 0, 0, 0);
  endtask

  initial begin
    bus.cfg_tsize = '0; bus.cfg_bsize = '0;
    bus.ts_en = 0; bus.t_sel = 0; bus.burst_en = 0; bus.b_sel = 0;
    bus.count_en = 0; bus.phase_start = 0;
    #12;
    chk("reset_tsz", bus.tsz, 1);
    chk("reset_bsz", bus.bsz, 0);
    chk("reset_rem", bus.rem_beats, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: full burst then decrement
    load(32, 8);
    chk("t1_blen", bus.burst_len, 8);
    beats(7);
    chk("t1_bsz_early", bus.bsz, 0);
    beats(1);
    step(0, 0, 0, 0, 0, 0);
    chk("t1_beat", bus.beat_cnt, 1);
    // restart for a clean 8-beat phase
    load(32, 8);
    beats(8);
    chk("t1_bsz", bus.bsz, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("t1_rem", bus.rem_beats, 24);
    chk("t1_tsz", bus.tsz, 0);
    chk("t1_tslb", bus.tslb, 0);

    // 2: short tail burst
    load(20, 8);
    beats(8);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    beats(8);
    step(1, 0, 0, 0, 0, 0);
    chk("t2_rem", bus.rem_beats, 4);
    chk("t2_tslb", bus.tslb, 1);
    step(0, 0, 1, 1, 0, 0);
    chk("t2_blen", bus.burst_len, 4);
    beats(4);
    chk("t2_bsz", bus.bsz, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("t2_rem0", bus.rem_beats, 0);
    chk("t2_tsz", bus.tsz, 1);
    step(0, 0, 1, 1, 0, 0);
    chk("t2_blen0", bus.burst_len, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t2_rem_sat", bus.rem_beats, 0);

    // 3: short transfer gets short first burst
    load(3, 8);
    chk("t3_blen", bus.burst_len, 3);
    chk("t3_rem", bus.rem_beats, 3);
    chk("t3_tslb", bus.tslb, 1);
    beats(3);
    chk("t3_bsz", bus.bsz, 1);

    // 4: bsize=0 behaves as 1
    load(2, 0);
    chk("t4_blen", bus.burst_len, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("t4_bsz_a", bus.bsz, 1);
    step(1, 0, 0, 0, 0, 0);
    chk("t4_rem", bus.rem_beats, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("t4_bsz_b", bus.bsz, 1);

    // 5: beat counter saturates, phase_start restarts it
    load(32, 8);
    beats(10);
    chk("t5_sat", bus.beat_cnt, 8);
    step(0, 0, 0, 0, 1, 1);
    chk("t5_restart", bus.beat_cnt, 1);
    chk("t5_bsz", bus.bsz, 0);
    // simultaneous decrement + reload uses pre-update values
    bus.cfg_bsize = 5'd8;
    step(1, 0, 1, 0, 0, 0);
    chk("t5_dec_rem", bus.rem_beats, 24);
    chk("t5_dec_blen", bus.burst_len, 8);
    chk("t5_dec_beat", bus.beat_cnt, 0);

    // zero-size transfer completes immediately
    load(0, 8);
    chk("tz_tsz", bus.tsz, 1);
    chk("tz_blen", bus.burst_len, 0);

    // 6: async reset mid-burst
    load(17, 8);
    beats(5);
    chk("t6_pre_beat", bus.beat_cnt, 5);
    #2 rst = 1'b0;
    #1;
    chk("t6_rem", bus.rem_beats, 0);
    chk("t6_blen", bus.burst_len, 0);
    chk("t6_beat", bus.beat_cnt, 0);
    chk("t6_tsz", bus.tsz, 1);
    chk("t6_bsz", bus.bsz, 0);
    chk("t6_tslb", bus.tslb, 0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    load(5, 4);
    chk("t6_reload_rem", bus.rem_beats, 5);
    chk("t6_reload_blen", bus.burst_len, 4);

    step(0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
